riscy_l2_cache_control: RTL and testbench
=========================================

Name: riscy_l2_cache_control

Overview:
- Control FSM that sequences the 4-way, 8-set, 256-bit-line L2 cache datapath.
- Accepts line-granular read/write requests from the L1/arbiter side and issues datapath strobes: array read, data/tag/valid/dirty/LRU loads, way select, address and data muxes.
- Drives the physical-memory handshake for dirty-victim writeback and line fill.
- Purely control: no data or address bits pass through it.

Parameters:
- s_mask, 32: bytes per line; width of data_write_en and data_in_sel.
- num_ways, 4: fixed at 4; any other value is a compile-time error.

Ports:
- clk in 1: clock, all state updates on rising edge.
- rst in 1: asynchronous active-high reset.
- mem_read in 1: upstream line read request, held until mem_resp.
- mem_write in 1: upstream line write request, held until mem_resp.
- mem_byte_enable256 in 32: per-byte write enable for write hits.
- mem_resp out 1: one-cycle completion pulse to upstream.
- hit in 4: per-way hit from datapath comparators.
- dirty in 4: per-way dirty & valid.
- valid_out in 4: per-way valid.
- lru_out in 2: LRU way of the current set.
- read_data out 1: data/tag array read strobe.
- load_tag out 1: tag load strobe.
- set_valid out 1: valid set strobe.
- set_dirty out 1: dirty set strobe.
- clear_dirty out 1: dirty clear strobe.
- way_sel out 2: target way for loads and LRU update (MRU).
- data_write_en out 32: byte enables to selected way.
- data_in_sel out 32: per byte, 1 = upstream wdata, 0 = pmem_rdata.
- bus_rdata_sel out 1: 0 = array data to upstream, 1 = pmem_rdata bypass.
- load_lru out 1: LRU update strobe.
- pmem_address_sel out 3: 0 = request address; 2..5 = victim way 0..3 tag address.
- pmem_read out 1: physical memory line read.
- pmem_write out 1: physical memory line write.
- pmem_resp in 1: physical memory completion, one cycle.

Behaviour:
- States: IDLE, LOOKUP, WRITEBACK, FILL, RELOAD. Registers: state, victim[1:0], is_write.
- Outputs are combinational from state, registers and inputs. Any output not listed for a state is 0.
- Reset (async, immediate): state=IDLE, victim=0, is_write=0. During reset outputs hold IDLE values: read_data=1, all others 0.
- IDLE:
  - read_data=1.
  - If mem_write, go to LOOKUP with is_write=1; else if mem_read, go to LOOKUP with is_write=0. mem_write wins if both are asserted.
- LOOKUP (array outputs valid this cycle):
  - read_data=1.
  - Read hit: mem_resp=1, bus_rdata_sel=0, load_lru=1, way_sel=index of hit bit; go to IDLE.
  - Write hit: additionally data_write_en=mem_byte_enable256, data_in_sel=all ones, set_dirty=1; go to IDLE.
  - Miss (hit==0), victim choice: lowest-index way with valid_out=0; if all ways valid, victim=lru_out. Latch victim.
  - Miss routing: if all ways valid and dirty[lru_out]=1, go to WRITEBACK; else go to FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address_sel=2+victim, read_data=1 (index stable, so pmem_wdata stays on the LRU way).
  - On pmem_resp, go to FILL.
- FILL:
  - pmem_read=1, pmem_address_sel=0.
  - In the pmem_resp cycle: way_sel=victim, data_write_en=all ones, data_in_sel=0, load_tag=1, set_valid=1, clear_dirty=1.
  - Read miss, same pmem_resp cycle: also mem_resp=1, bus_rdata_sel=1, load_lru=1; go to IDLE.
  - Write miss: go to RELOAD.
- RELOAD:
  - read_data=1; go to LOOKUP, which then resolves as a write hit.
- Latency, counted from the first IDLE cycle with a request:
  - Hit: mem_resp in the next cycle.
  - Clean read miss: mem_resp in the pmem_resp cycle of FILL.
  - Write miss: 2 cycles after FILL's pmem_resp.
- pmem_read and pmem_write are held high until pmem_resp and are never asserted together.
- Upstream must hold request and address until mem_resp. A request deasserted mid-miss is ignored; the fill still completes.
- hit with more than one bit set is illegal: assertion error, way_sel falls to the lowest set bit.
- Reset mid-WRITEBACK or mid-FILL drops pmem_read/pmem_write immediately. No array write occurs after reset asserts.

Test Plan:
- Cold read miss, set 3, all ways invalid -> victim=0, FILL with pmem_address_sel=0; on pmem_resp: load_tag=1, set_valid=1, mem_resp=1, bus_rdata_sel=1, way_sel=0. Repeat read -> mem_resp one cycle after request, bus_rdata_sel=0.
- Write hit on way 2, byte_enable=0x0000_00FF -> in LOOKUP: data_write_en=0x0000_00FF, data_in_sel=all ones, set_dirty=1, way_sel=2, mem_resp=1; no pmem activity.
- All valid, lru_out=1, dirty=4'b0010, read miss -> pmem_write with pmem_address_sel=3 until pmem_resp (delayed 10 cycles), then pmem_read with pmem_address_sel=0, then mem_resp; pmem_read and pmem_write never both high.
- Write miss, clean victim -> FILL (data_in_sel=0, clear_dirty=1) -> RELOAD -> LOOKUP write hit, set_dirty=1, mem_resp exactly 2 cycles after pmem_resp.
- mem_read and mem_write asserted together -> handled as write (set_dirty on hit). Valid ways 0,1,3 with way 2 invalid -> victim=2, no writeback.
- rst pulsed mid-FILL (pmem_read=1) -> pmem_read=0 in the same cycle, state IDLE, read_data=1; next request is serviced normally.

Source files
------------

// File: rtl/riscy_l2_cache_control.sv
// Control FSM for the 4-way, 8-set L2 cache: sequences lookup, dirty-victim
// writeback, line fill and the post-fill reload for write misses.
module riscy_l2_cache_control #(
    parameter int s_mask   = 32,
    parameter int num_ways = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [s_mask-1:0] mem_byte_enable256,
    output logic              mem_resp,
    input  logic [3:0]        hit,
    input  logic [3:0]        dirty,
    input  logic [3:0]        valid_out,
    input  logic [1:0]        lru_out,
    output logic              read_data,
    output logic              load_tag,
    output logic              set_valid,
    output logic              set_dirty,
    output logic              clear_dirty,
    output logic [1:0]        way_sel,
    output logic [s_mask-1:0] data_write_en,
    output logic [s_mask-1:0] data_in_sel,
    output logic              bus_rdata_sel,
    output logic              load_lru,
    output logic [2:0]        pmem_address_sel,
    output logic              pmem_read,
    output logic              pmem_write,
    input  logic              pmem_resp
);

    generate
        if (num_ways != 4) begin : g_bad_num_ways
            $error("riscy_l2_cache_control supports exactly 4 ways");
        end
    endgenerate

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] LOOKUP    = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] FILL      = 3'd3;
    localparam logic [2:0] RELOAD    = 3'd4;

    logic [2:0] state_reg, state_next;
    logic [1:0] victim_reg, victim_next;
    logic       is_write_reg, is_write_next;

    logic [1:0] hit_way;
    logic [1:0] invalid_way;
    logic       all_valid;

    // Lowest-index encoders; a multi-bit hit resolves to its lowest set bit.
    always_comb begin
        hit_way     = 2'd0;
        invalid_way = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (hit[i])
                hit_way = 2'(i);
            if (!valid_out[i])
                invalid_way = 2'(i);
        end
    end

    assign all_valid = &valid_out;

    always_comb begin
        state_next       = state_reg;
        victim_next      = victim_reg;
        is_write_next    = is_write_reg;
        mem_resp         = 1'b0;
        read_data        = 1'b0;
        load_tag         = 1'b0;
        set_valid        = 1'b0;
        set_dirty        = 1'b0;
        clear_dirty      = 1'b0;
        way_sel          = 2'd0;
        data_write_en    = '0;
        data_in_sel      = '0;
        bus_rdata_sel    = 1'b0;
        load_lru         = 1'b0;
        pmem_address_sel = 3'd0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;

        case (state_reg)
            IDLE: begin
                read_data = 1'b1;
                if (mem_write) begin
                    state_next    = LOOKUP;
                    is_write_next = 1'b1;
                end else if (mem_read) begin
                    state_next    = LOOKUP;
                    is_write_next = 1'b0;
                end
            end

            LOOKUP: begin
                read_data = 1'b1;
                if (|hit) begin
                    mem_resp   = 1'b1;
                    load_lru   = 1'b1;
                    way_sel    = hit_way;
                    state_next = IDLE;
                    if (is_write_reg) begin
                        data_write_en = mem_byte_enable256;
                        data_in_sel   = '1;
                        set_dirty     = 1'b1;
                    end
                end else begin
                    victim_next = all_valid ? lru_out : invalid_way;
                    state_next  = (all_valid && dirty[lru_out]) ? WRITEBACK : FILL;
                end
            end

            WRITEBACK: begin
                // Keep the array read active so the victim line stays on pmem_wdata.
                read_data        = 1'b1;
                pmem_write       = 1'b1;
                pmem_address_sel = 3'd2 + {1'b0, victim_reg};
                if (pmem_resp)
                    state_next = FILL;
            end

            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    way_sel       = victim_reg;
                    data_write_en = '1;
                    load_tag      = 1'b1;
                    set_valid     = 1'b1;
                    clear_dirty   = 1'b1;
                    if (is_write_reg) begin
                        state_next = RELOAD;
                    end else begin
                        mem_resp      = 1'b1;
                        bus_rdata_sel = 1'b1;
                        load_lru      = 1'b1;
                        state_next    = IDLE;
                    end
                end
            end

            RELOAD: begin
                // One array read so the freshly loaded line hits on the next lookup.
                read_data  = 1'b1;
                state_next = LOOKUP;
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            victim_reg   <= 2'd0;
            is_write_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            victim_reg   <= victim_next;
            is_write_reg <= is_write_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_reg == LOOKUP)
            assert ($onehot0(hit)) else $error("multiple ways hit: %b", hit);
    end

endmodule

// File: tb/tb_riscy_l2_cache_control.sv
// Directed bench for riscy_l2_cache_control: per-cycle expected output vectors
// are queued as inputs are driven and compared at the following falling edge.
module tb_riscy_l2_cache_control;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [31:0] mem_byte_enable256;
    logic        mem_resp;
    logic [3:0]  hit, dirty, valid_out;
    logic [1:0]  lru_out;
    logic        read_data, load_tag, set_valid, set_dirty, clear_dirty;
    logic [1:0]  way_sel;
    logic [31:0] data_write_en, data_in_sel;
    logic        bus_rdata_sel, load_lru;
    logic [2:0]  pmem_address_sel;
    logic        pmem_read, pmem_write, pmem_resp;

    typedef struct packed {
        logic        mem_resp;
        logic        read_data;
        logic        load_tag;
        logic        set_valid;
        logic        set_dirty;
        logic        clear_dirty;
        logic [1:0]  way_sel;
        logic [31:0] data_write_en;
        logic [31:0] data_in_sel;
        logic        bus_rdata_sel;
        logic        load_lru;
        logic [2:0]  pmem_address_sel;
        logic        pmem_read;
        logic        pmem_write;
    } outs_t;

    typedef struct {
        string tag;
        outs_t exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    outs_t     act;
    int        pass_count  = 0;
    int        check_count = 0;

    always #5 clk = ~clk;

    riscy_l2_cache_control #(.s_mask(32), .num_ways(4)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable256(mem_byte_enable256), .mem_resp(mem_resp),
        .hit(hit), .dirty(dirty), .valid_out(valid_out), .lru_out(lru_out),
        .read_data(read_data), .load_tag(load_tag), .set_valid(set_valid),
        .set_dirty(set_dirty), .clear_dirty(clear_dirty), .way_sel(way_sel),
        .data_write_en(data_write_en), .data_in_sel(data_in_sel),
        .bus_rdata_sel(bus_rdata_sel), .load_lru(load_lru),
        .pmem_address_sel(pmem_address_sel), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    assign act = {mem_resp, read_data, load_tag, set_valid, set_dirty, clear_dirty,
                  way_sel, data_write_en, data_in_sel, bus_rdata_sel, load_lru,
                  pmem_address_sel, pmem_read, pmem_write};

    function automatic outs_t o_rd();
        outs_t o = '0;
        o.read_data = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_hit(logic [1:0] w, logic wr, logic [31:0] be);
        outs_t o = o_rd();
        o.mem_resp = 1'b1;
        o.load_lru = 1'b1;
        o.way_sel  = w;
        if (wr) begin
            o.data_write_en = be;
            o.data_in_sel   = '1;
            o.set_dirty     = 1'b1;
        end
        return o;
    endfunction

    function automatic outs_t o_wb(logic [2:0] sel);
        outs_t o = o_rd();
        o.pmem_write       = 1'b1;
        o.pmem_address_sel = sel;
        return o;
    endfunction

    function automatic outs_t o_fill_wait();
        outs_t o = '0;
        o.pmem_read = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_fill_resp(logic [1:0] w, logic rd_miss);
        outs_t o = o_fill_wait();
        o.way_sel       = w;
        o.data_write_en = '1;
        o.load_tag      = 1'b1;
        o.set_valid     = 1'b1;
        o.clear_dirty   = 1'b1;
        if (rd_miss) begin
            o.mem_resp      = 1'b1;
            o.bus_rdata_sel = 1'b1;
            o.load_lru      = 1'b1;
        end
        return o;
    endfunction

    // Queue the expectation for the current input set, compare on the falling
    // edge, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input outs_t e);
        sb_entry_t ent;
        sb_entry_t got;
        ent.tag = tag;
        ent.exp = e;
        sb_q.push_back(ent);
        @(negedge clk);
        got = sb_q.pop_front();
        check_count++;
        assert (act === got.exp) pass_count++;
        else $error("FAIL %s observed=%h expected=%h", got.tag, act, got.exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        mem_read = 1'b1; mem_write = 1'b0; mem_byte_enable256 = '0;
        hit = 4'b0000; dirty = 4'b0000; valid_out = 4'b0000; lru_out = 2'd0;
        pmem_resp = 1'b1;
        cyc("reset_idle", o_rd());
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b0;
        cyc("post_reset_idle", o_rd());

        // Cold read miss, all ways invalid.
        mem_read = 1'b1;
        cyc("cold_idle", o_rd());
        cyc("cold_lookup_miss", o_rd());
        cyc("cold_fill_wait", o_fill_wait());
        pmem_resp = 1'b1;
        cyc("cold_fill_resp", o_fill_resp(2'd0, 1'b1));
        pmem_resp = 1'b0; mem_read = 1'b0;
        cyc("cold_back_idle", o_rd());

        // Same line again hits in way 0.
        mem_read = 1'b1; valid_out = 4'b0001;
        cyc("rehit_idle", o_rd());
        hit = 4'b0001;
        cyc("rehit_lookup", o_hit(2'd0, 1'b0, 32'h0));
        mem_read = 1'b0; hit = 4'b0000;
        cyc("rehit_back_idle", o_rd());

        // Write hit on way 2 with a partial byte enable.
        mem_write = 1'b1; mem_byte_enable256 = 32'h0000_00FF; valid_out = 4'b0100;
        cyc("wrhit_idle", o_rd());
        hit = 4'b0100;
        cyc("wrhit_lookup", o_hit(2'd2, 1'b1, 32'h0000_00FF));
        mem_write = 1'b0; hit = 4'b0000;
        cyc("wrhit_back_idle", o_rd());

        // Dirty LRU victim (way 1) with a slow writeback.
        mem_read = 1'b1; valid_out = 4'b1111; lru_out = 2'd1; dirty = 4'b0010;
        cyc("wb_idle", o_rd());
        cyc("wb_lookup_miss", o_rd());
        for (int i = 0; i < 10; i++)
            cyc($sformatf("wb_wait%0d", i), o_wb(3'd3));
        pmem_resp = 1'b1;
        cyc("wb_resp", o_wb(3'd3));
        pmem_resp = 1'b0;
        cyc("wb_fill_wait", o_fill_wait());
        pmem_resp = 1'b1;
        cyc("wb_fill_resp", o_fill_resp(2'd1, 1'b1));
        pmem_resp = 1'b0; mem_read = 1'b0; dirty = 4'b0000;
        cyc("wb_back_idle", o_rd());

        // Write miss with a clean LRU victim (way 3): fill, reload, write hit.
        mem_write = 1'b1; mem_byte_enable256 = 32'hF0F0_0000; lru_out = 2'd3;
        cyc("wm_idle", o_rd());
        cyc("wm_lookup_miss", o_rd());
        pmem_resp = 1'b1;
        cyc("wm_fill_resp", o_fill_resp(2'd3, 1'b0));
        pmem_resp = 1'b0;
        cyc("wm_reload", o_rd());
        hit = 4'b1000;
        cyc("wm_lookup_hit", o_hit(2'd3, 1'b1, 32'hF0F0_0000));
        mem_write = 1'b0; hit = 4'b0000;
        cyc("wm_back_idle", o_rd());

        // Simultaneous read and write requests are treated as a write.
        mem_read = 1'b1; mem_write = 1'b1; mem_byte_enable256 = 32'h0000_0F00;
        cyc("both_idle", o_rd());
        hit = 4'b0010;
        cyc("both_lookup", o_hit(2'd1, 1'b1, 32'h0000_0F00));
        mem_read = 1'b0; mem_write = 1'b0; hit = 4'b0000;
        cyc("both_back_idle", o_rd());

        // Way 2 invalid: it is the victim even though the LRU way is dirty.
        mem_read = 1'b1; valid_out = 4'b1011; lru_out = 2'd0; dirty = 4'b1011;
        cyc("inv_idle", o_rd());
        cyc("inv_lookup_miss", o_rd());
        pmem_resp = 1'b1;
        cyc("inv_fill_resp", o_fill_resp(2'd2, 1'b1));
        pmem_resp = 1'b0; mem_read = 1'b0; dirty = 4'b0000;
        cyc("inv_back_idle", o_rd());

        // Reset mid-fill drops pmem_read at once and suppresses the array write.
        mem_read = 1'b1; valid_out = 4'b0000;
        cyc("rstf_idle", o_rd());
        cyc("rstf_lookup_miss", o_rd());
        cyc("rstf_fill_wait", o_fill_wait());
        rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b1;
        cyc("rstf_in_reset", o_rd());
        rst = 1'b0; pmem_resp = 1'b0; mem_read = 1'b1; valid_out = 4'b0001;
        cyc("rstf_next_idle", o_rd());
        hit = 4'b0001;
        cyc("rstf_next_hit", o_hit(2'd0, 1'b0, 32'h0));
        mem_read = 1'b0; hit = 4'b0000;
        cyc("rstf_back_idle", o_rd());

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
